// File: rtl/raw2rgb_scaler.sv
// -----------------------------------------------------------------------------
// raw2rgb_scaler
//
// Bayer-to-RGB converter for the CCD capture path. It keeps one line of raw
// samples in an internal RAM. This gives a 2x2 window: the current row, the row
// above, the current column and the previous column. From that window it builds
// one RGB pixel.
//
// Output modes (latched at the (0,0) sample of each frame):
//   mode 0 : one pixel per complete 2x2 quad (x odd, y odd) -> (W/2) x (H/2)
//   mode 1 : one pixel per accepted sample with x >= 1 and y >= 1
//
// Optional feature macro:
//   RAW2RGB_SCALER_GREEN_ROUND_EN  defined   -> G = (G1 + G2 + 1) >> 1
//                                  undefined -> G = (G1 + G2) >> 1 (floor)
//
// Parameters:
//   DW      raw sample width and width of each colour output
//   LINE_W  maximum pixels per line (depth of the line RAM)
//   PATTERN colour at (even row, even column): 0=RGGB 1=GRBG 2=GBRG 3=BGGR
//
// Ports:
//   iCLK     in   1   pixel clock, rising edge
//   iRST     in   1   asynchronous reset, active low
//   iDATA    in   DW  raw Bayer sample
//   iDVAL    in   1   iDATA / iX_Cont / iY_Cont valid this cycle
//   iX_Cont  in   11  column of the current sample
//   iY_Cont  in   11  row of the current sample
//   iMODE    in   1   0 = 2x decimate, 1 = full resolution
//   oRed     out  DW  red component
//   oGreen   out  DW  green component
//   oBlue    out  DW  blue component
//   oDVAL    out  1   one-cycle strobe per output pixel
//
// Handshake: there is no backpressure. A sample is taken on every clock edge
// where iDVAL=1 and iX_Cont < LINE_W. oDVAL is a one-cycle strobe that comes
// two cycles after the accepted sample. The RGB outputs hold their value
// between strobes.
// -----------------------------------------------------------------------------
module raw2rgb_scaler #(
    parameter int DW      = 10,
    parameter int LINE_W  = 1280,
    parameter int PATTERN = 0
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [DW-1:0] iDATA,
    input  logic          iDVAL,
    input  logic [10:0]   iX_Cont,
    input  logic [10:0]   iY_Cont,
    input  logic          iMODE,
    output logic [DW-1:0] oRed,
    output logic [DW-1:0] oGreen,
    output logic [DW-1:0] oBlue,
    output logic          oDVAL
);

    localparam int         AW       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [11:0] LINE_LIM = 12'(LINE_W);
    // PATTERN is also the {row,col} offset of the red site inside a quad.
    localparam logic [1:0] PH_OFS   = 2'(PATTERN);

    // ------------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------------
    logic          accept;
    logic [AW-1:0] addr;
    logic          frame_start;
    logic          qualify;

    assign accept      = iDVAL && ({1'b0, iX_Cont} < LINE_LIM);
    assign addr        = iX_Cont[AW-1:0];
    assign frame_start = accept && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);

    // ------------------------------------------------------------------------
    // Line RAM. The read is asynchronous, and the write lands on the clock
    // edge. So a read and a write to the same column in the same cycle return
    // the previous row's sample. The contents are never cleared.
    // ------------------------------------------------------------------------
    logic [DW-1:0] line_ram [LINE_W];
    logic [DW-1:0] ram_rd;

    assign ram_rd = line_ram[addr];

    always_ff @(posedge iCLK) begin
        if (accept) begin
            line_ram[addr] <= iDATA;
        end
    end

    // ------------------------------------------------------------------------
    // Frame control: mode latch and priming flag
    // ------------------------------------------------------------------------
    logic mode_q;
    logic primed;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            mode_q <= 1'b0;
            primed <= 1'b0;
        end else begin
            if (frame_start) begin
                mode_q <= iMODE;
            end
            if (accept && (iY_Cont == 11'd0)) begin
                primed <= 1'b1;
            end
        end
    end

    // Row 0 never qualifies, so the registered priming flag is enough here.
    // The flag only blocks stale RAM data after a reset in the middle of a frame.
    always_comb begin
        qualify = 1'b0;
        if (mode_q) begin
            qualify = (iX_Cont != 11'd0) && (iY_Cont != 11'd0);
        end else begin
            qualify = iX_Cont[0] && iY_Cont[0];
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: the 2x2 window. It only moves on accepted samples, so gaps
    // freeze it.
    //   cur = (y, x)   curd = (y, x-1)   up = (y-1, x)   upd = (y-1, x-1)
    // ------------------------------------------------------------------------
    logic [DW-1:0] s1_cur;
    logic [DW-1:0] s1_curd;
    logic [DW-1:0] s1_up;
    logic [DW-1:0] s1_upd;
    logic [1:0]    s1_ph;
    logic          s1_vld;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s1_cur  <= '0;
            s1_curd <= '0;
            s1_up   <= '0;
            s1_upd  <= '0;
            s1_ph   <= '0;
            s1_vld  <= 1'b0;
        end else begin
            s1_vld <= accept && qualify && primed;
            if (accept) begin
                s1_cur  <= iDATA;
                s1_curd <= s1_cur;
                s1_up   <= ram_rd;
                s1_upd  <= s1_up;
                s1_ph   <= {iY_Cont[0], iX_Cont[0]} ^ PH_OFS;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: tap mux and green average.
    // ph gives the current sample's site relative to an RGGB quad:
    //   00 = R, 01 = G on the red row, 10 = G on the blue row, 11 = B.
    // ------------------------------------------------------------------------
    logic [DW-1:0] mux_r;
    logic [DW-1:0] mux_b;
    logic [DW-1:0] mux_g1;
    logic [DW-1:0] mux_g2;
    logic [DW:0]   green_sum;
    logic [DW-1:0] green;

    always_comb begin
        mux_r  = s1_cur;
        mux_b  = s1_upd;
        mux_g1 = s1_curd;
        mux_g2 = s1_up;
        case (s1_ph)
            2'b01: begin
                mux_r  = s1_curd;
                mux_b  = s1_up;
                mux_g1 = s1_cur;
                mux_g2 = s1_upd;
            end
            2'b10: begin
                mux_r  = s1_up;
                mux_b  = s1_curd;
                mux_g1 = s1_cur;
                mux_g2 = s1_upd;
            end
            2'b11: begin
                mux_r  = s1_upd;
                mux_b  = s1_cur;
                mux_g1 = s1_curd;
                mux_g2 = s1_up;
            end
            default: begin
                mux_r  = s1_cur;
                mux_b  = s1_upd;
                mux_g1 = s1_curd;
                mux_g2 = s1_up;
            end
        endcase
    end

    // The sum is DW+1 bits wide. Even with the +1 rounding term, the largest
    // value (2^(DW+1) - 1) still fits, so green never wraps.
`ifdef RAW2RGB_SCALER_GREEN_ROUND_EN
    assign green_sum = {1'b0, mux_g1} + {1'b0, mux_g2} + (DW+1)'(1);
`else
    assign green_sum = {1'b0, mux_g1} + {1'b0, mux_g2};
`endif
    assign green = green_sum[DW:1];

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
            oDVAL  <= 1'b0;
        end else begin
            oDVAL <= s1_vld;
            if (s1_vld) begin
                oRed   <= mux_r;
                oGreen <= green;
                oBlue  <= mux_b;
            end
        end
    end

endmodule

// File: tb/tb_raw2rgb_scaler.sv
// -----------------------------------------------------------------------------
// tb_raw2rgb_scaler
//
// Two instances share one stimulus stream: an RGGB instance (PATTERN=0) and a
// BGGR instance (PATTERN=3). Both use LINE_W=8, so out-of-range columns are
// cheap to reach. Each accepted sample that should produce a pixel pushes an
// entry to that instance's expected queue. The entry holds the arrival cycle
// and the RGB value. The expected RGB comes from a window model that works
// from the frame image the bench holds.
// -----------------------------------------------------------------------------
module tb_raw2rgb_scaler;

  localparam int DW = 10;
  localparam int LW = 8;
  localparam int EW = 32 + 3 * DW;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data = '0;
  logic          dval = 1'b0;
  logic [10:0]   xc = '0;
  logic [10:0]   yc = '0;
  logic          mode_in = 1'b0;

  logic [DW-1:0] r0, g0, b0, r3, g3, b3;
  logic          v0, v3;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  raw2rgb_scaler #(.DW(DW), .LINE_W(LW), .PATTERN(0)) dut0 (
    .iCLK(clk), .iRST(rst_n), .iDATA(data), .iDVAL(dval),
    .iX_Cont(xc), .iY_Cont(yc), .iMODE(mode_in),
    .oRed(r0), .oGreen(g0), .oBlue(b0), .oDVAL(v0)
  );

  raw2rgb_scaler #(.DW(DW), .LINE_W(LW), .PATTERN(3)) dut3 (
    .iCLK(clk), .iRST(rst_n), .iDATA(data), .iDVAL(dval),
    .iX_Cont(xc), .iY_Cont(yc), .iMODE(mode_in),
    .oRed(r3), .oGreen(g3), .oBlue(b3), .oDVAL(v3)
  );

  // ---------------------------------------------------------------- scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q3[$];
  logic [29:0]   got0[$];
  logic [29:0]   got3[$];
  logic [EW-1:0] e0, e3;

  logic [DW-1:0] img [0:7][0:7];
  bit            m_primed = 1'b0;
  bit            m_mode = 1'b0;

  // Window model: pick out the colour sites of the 2x2 block that ends at (y,x).
  function automatic logic [29:0] model(input int p, input int y, input int x);
    int gs;
    int yy;
    int xx;
    int c;
    logic [DW-1:0] r;
    logic [DW-1:0] b;
    logic [DW-1:0] g;
    gs = 0;
    r  = '0;
    b  = '0;
    for (int dy = 0; dy < 2; dy++) begin
      for (int dx = 0; dx < 2; dx++) begin
        yy = y - 1 + dy;
        xx = x - 1 + dx;
        c  = (((yy % 2) << 1) | (xx % 2)) ^ p;
        if (c == 0) r = img[yy][xx];
        else if (c == 3) b = img[yy][xx];
        else gs += int'(img[yy][xx]);
      end
    end
`ifdef RAW2RGB_SCALER_GREEN_ROUND_EN
    gs += 1;
`endif
    g = 10'(gs >> 1);
    return {r, g, b};
  endfunction

  always @(negedge clk) begin
    if (rst_n && v0) begin
      got0.push_back({r0, g0, b0});
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL rggb_unexpected_strobe cyc=%0d got rgb=%0d,%0d,%0d required no strobe", cyc, r0, g0, b0);
      end else begin
        e0 = exp_q0.pop_front();
        if ({32'(cyc), r0, g0, b0} !== e0) begin
          errors++;
          $display("FAIL rggb_pixel got cyc=%0d rgb=%0d,%0d,%0d required cyc=%0d rgb=%0d,%0d,%0d",
                   cyc, r0, g0, b0, e0[61:30], e0[29:20], e0[19:10], e0[9:0]);
        end
      end
    end
    if (rst_n && v3) begin
      got3.push_back({r3, g3, b3});
      checks++;
      if (exp_q3.size() == 0) begin
        errors++;
        $display("FAIL bggr_unexpected_strobe cyc=%0d got rgb=%0d,%0d,%0d required no strobe", cyc, r3, g3, b3);
      end else begin
        e3 = exp_q3.pop_front();
        if ({32'(cyc), r3, g3, b3} !== e3) begin
          errors++;
          $display("FAIL bggr_pixel got cyc=%0d rgb=%0d,%0d,%0d required cyc=%0d rgb=%0d,%0d,%0d",
                   cyc, r3, g3, b3, e3[61:30], e3[29:20], e3[19:10], e3[9:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive_sample(input int x, input int y, input logic [DW-1:0] d, input logic md);
    data    = d;
    xc      = 11'(x);
    yc      = 11'(y);
    dval    = 1'b1;
    mode_in = md;
    if (x < LW) begin
      if (x == 0 && y == 0) m_mode = md;
      if (m_primed && (m_mode ? (x >= 1 && y >= 1) : (x % 2 == 1 && y % 2 == 1))) begin
        exp_q0.push_back({32'(cyc + 2), model(0, y, x)});
        exp_q3.push_back({32'(cyc + 2), model(3, y, x)});
      end
      if (y == 0) m_primed = 1'b1;
    end
    @(posedge clk);
    #1;
    dval = 1'b0;
  endtask

  task automatic idle(input int n);
    dval = 1'b0;
    data = 10'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_row(input int y, input int x0, input int x1, input logic md,
                           input int gap_pct, input bit ovf);
    for (int x = x0; x <= x1; x++) begin
      if (int'($urandom_range(0, 99)) < gap_pct) idle(int'($urandom_range(1, 3)));
      drive_sample(x, y, img[y][x], md);
      if (ovf && x == 2) drive_sample(LW, y, 10'($urandom), md);
    end
  endtask

  task automatic drive_frame(input int w, input int h, input logic md0, input int sw_row,
                             input logic md1, input int gap_pct, input bit ovf);
    for (int y = 0; y < h; y++) begin
      drive_row(y, 0, w - 1, (y >= sw_row) ? md1 : md0, gap_pct, ovf);
      idle(2);
    end
    idle(4);
  endtask

  task automatic fill_img();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        img[y][x] = 10'($urandom_range(0, 1023));
  endtask

  task automatic clear_got();
    got0.delete();
    got3.delete();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({v0, r0, g0, b0} !== 31'd0) begin
      errors++;
      $display("FAIL reset_rggb got v=%0b rgb=%0d,%0d,%0d required all zero", v0, r0, g0, b0);
    end
    checks++;
    if ({v3, r3, g3, b3} !== 31'd0) begin
      errors++;
      $display("FAIL reset_bggr got v=%0b rgb=%0d,%0d,%0d required all zero", v3, r3, g3, b3);
    end
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mode0();
    logic [29:0] want;
`ifdef RAW2RGB_SCALER_GREEN_ROUND_EN
    want = {10'd100, 10'd251, 10'd400};
`else
    want = {10'd100, 10'd250, 10'd400};
`endif
    fill_img();
    img[0][0] = 10'd100;
    img[0][1] = 10'd200;
    img[1][0] = 10'd301;
    img[1][1] = 10'd400;
    clear_got();
    drive_frame(4, 4, 1'b0, 99, 1'b0, 0, 1'b0);
    checks++;
    if (got0.size() != 4) begin
      errors++;
      $display("FAIL mode0_count_rggb got %0d required 4", got0.size());
    end
    checks++;
    if (got3.size() != 4) begin
      errors++;
      $display("FAIL mode0_count_bggr got %0d required 4", got3.size());
    end
    checks++;
    if (got0.size() == 0 || got0[0] !== want) begin
      errors++;
      $display("FAIL mode0_first_quad got %h required %h", (got0.size() != 0) ? got0[0] : 30'h0, want);
    end
  endtask

  task automatic test_mode1_bggr();
    logic [29:0] want;
    int          gs;
    fill_img();
    clear_got();
    drive_frame(4, 4, 1'b1, 99, 1'b1, 0, 1'b0);
    gs = int'(img[0][1]) + int'(img[1][0]);
`ifdef RAW2RGB_SCALER_GREEN_ROUND_EN
    gs += 1;
`endif
    want = {img[1][1], 10'(gs >> 1), img[0][0]};
    checks++;
    if (got3.size() != 9) begin
      errors++;
      $display("FAIL mode1_count_bggr got %0d required 9", got3.size());
    end
    checks++;
    if (got0.size() != 9) begin
      errors++;
      $display("FAIL mode1_count_rggb got %0d required 9", got0.size());
    end
    checks++;
    if (got3.size() == 0 || got3[0] !== want) begin
      errors++;
      $display("FAIL mode1_bggr_at_1_1 got %h required %h", (got3.size() != 0) ? got3[0] : 30'h0, want);
    end
  endtask

  task automatic test_green_extremes();
    fill_img();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        if ((x + y) % 2 == 1) img[y][x] = 10'd1023;
    clear_got();
    drive_frame(4, 4, 1'b1, 99, 1'b1, 0, 1'b0);
    checks++;
    if (got0.size() != 9) begin
      errors++;
      $display("FAIL green_ext_count got %0d required 9", got0.size());
    end
    foreach (got0[i]) begin
      checks++;
      if (got0[i][19:10] !== 10'd1023) begin
        errors++;
        $display("FAIL green_ext_rggb idx=%0d got %0d required 1023", i, got0[i][19:10]);
      end
    end
    foreach (got3[i]) begin
      checks++;
      if (got3[i][19:10] !== 10'd1023) begin
        errors++;
        $display("FAIL green_ext_bggr idx=%0d got %0d required 1023", i, got3[i][19:10]);
      end
    end
  endtask

  task automatic test_gaps_overflow();
    fill_img();
    clear_got();
    drive_frame(6, 4, 1'b1, 99, 1'b1, 30, 1'b1);
    checks++;
    if (got0.size() != 15) begin
      errors++;
      $display("FAIL gaps_count_rggb got %0d required 15", got0.size());
    end
    checks++;
    if (got3.size() != 15) begin
      errors++;
      $display("FAIL gaps_count_bggr got %0d required 15", got3.size());
    end
  endtask

  task automatic test_mode_change();
    fill_img();
    clear_got();
    drive_frame(4, 4, 1'b0, 2, 1'b1, 0, 1'b0);
    checks++;
    if (got0.size() != 4) begin
      errors++;
      $display("FAIL mode_change_0to1_same_frame got %0d required 4", got0.size());
    end
    fill_img();
    clear_got();
    drive_frame(4, 4, 1'b1, 2, 1'b0, 0, 1'b0);
    checks++;
    if (got0.size() != 9) begin
      errors++;
      $display("FAIL mode_change_new_frame_1to0 got %0d required 9", got0.size());
    end
    fill_img();
    clear_got();
    drive_frame(4, 4, 1'b0, 99, 1'b0, 0, 1'b0);
    checks++;
    if (got0.size() != 4) begin
      errors++;
      $display("FAIL mode_change_next_frame got %0d required 4", got0.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    int n3;
    fill_img();
    clear_got();
    for (int y = 0; y < 3; y++) begin
      drive_row(y, 0, 3, 1'b1, 0, 1'b0);
      idle(2);
    end
    drive_row(3, 0, 1, 1'b1, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({v0, r0, g0, b0, v3, r3, g3, b3} !== 62'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got v0=%0b r0=%0d v3=%0b r3=%0d required all zero", v0, r0, v3, r3);
    end
    exp_q0.delete();
    exp_q3.delete();
    m_primed = 1'b0;
    m_mode = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = got0.size();
    n3 = got3.size();
    drive_row(3, 2, 3, 1'b1, 0, 1'b0);
    idle(6);
    checks++;
    if (got0.size() != n0 || got3.size() != n3) begin
      errors++;
      $display("FAIL reset_mid_no_strobe got %0d/%0d required %0d/%0d", got0.size(), got3.size(), n0, n3);
    end
    fill_img();
    clear_got();
    drive_frame(4, 4, 1'b1, 99, 1'b1, 0, 1'b0);
    checks++;
    if (got0.size() != 9 || got3.size() != 9) begin
      errors++;
      $display("FAIL reset_mid_next_frame got %0d/%0d required 9/9", got0.size(), got3.size());
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1_bggr();
    test_green_extremes();
    test_gaps_overflow();
    test_mode_change();
    test_reset_mid_frame();
    idle(4);
    checks++;
    if (exp_q0.size() != 0 || exp_q3.size() != 0) begin
      errors++;
      $display("FAIL drain got pending %0d/%0d required 0/0", exp_q0.size(), exp_q3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
